// File: rtl/mux_pkg.sv
// mux_pkg
//   Shared definitions for the team's 8:1 byte mux and its 1:8 demux
//   counterpart. Holds channel count, select width, the channel index
//   type, the default lane data width and a one-hot decode helper.
//   No ports (package).
package mux_pkg;

  localparam int NUM_CH    = 8;
  localparam int SEL_W     = 3;
  localparam int DEF_WIDTH = 8;

  typedef logic [SEL_W-1:0] ch_idx_t;

  // One-hot lane mask for a channel index.
  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_idx_t ch);
    logic [NUM_CH-1:0] mask;
    mask     = '0;
    mask[ch] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot
//   One-entry holding register for a single demux output lane, with a
//   valid/ready handshake towards the lane consumer.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset; clears data and full flag
//     load   write din into the register this cycle (takes priority
//            over a simultaneous drain, so drain+load leaves no bubble)
//     din    data to load
//     dout   registered lane data
//     valid  register holds an unconsumed byte
//     ready  consumer accepts dout this cycle
module demux_slot
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready
);

  logic [WIDTH-1:0] hold;
  logic             full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
      full <= 1'b0;
    end else if (load) begin
      hold <= din;
      full <= 1'b1;
    end else if (full && ready) begin
      // drain only clears the flag; the data stays visible but invalid
      full <= 1'b0;
    end
  end

  assign dout  = hold;
  assign valid = full;

endmodule

// File: rtl/demux8_buf.sv
// demux8_buf
//   Buffered 1-to-8 byte demultiplexer. A single valid/ready input stream
//   is steered into one of eight lanes, each with its own one-entry
//   holding register, so a stalled lane only blocks bytes addressed to it.
//   Optional feature macro: DEMUX_AUTOSEQ_EN
//     defined   - destination comes from an internal round-robin pointer
//                 (ch_ptr) that advances on every accepted byte; s ignored
//     undefined - destination is s; ch_ptr is tied to zero
//   Ports:
//     clk       rising-edge clock
//     rst_n     synchronous active-low reset
//     d         input data
//     s         destination channel for d
//     d_valid   input valid
//     d_ready   input ready (combinational from select and y_ready only)
//     y0..y7    lane data
//     y_valid   per-lane valid
//     y_ready   per-lane ready
//     ch_ptr    next destination channel in auto-sequence mode
//     xfer_cnt  accepted-transfer count, wraps
module demux8_buf
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  d,
  input  logic [SEL_W-1:0]  s,
  input  logic              d_valid,
  output logic              d_ready,
  output logic [WIDTH-1:0]  y0,
  output logic [WIDTH-1:0]  y1,
  output logic [WIDTH-1:0]  y2,
  output logic [WIDTH-1:0]  y3,
  output logic [WIDTH-1:0]  y4,
  output logic [WIDTH-1:0]  y5,
  output logic [WIDTH-1:0]  y6,
  output logic [WIDTH-1:0]  y7,
  output logic [NUM_CH-1:0] y_valid,
  input  logic [NUM_CH-1:0] y_ready,
  output logic [SEL_W-1:0]  ch_ptr,
  output logic [CNT_W-1:0]  xfer_cnt
);

  ch_idx_t           sel;
  logic              accept;
  logic [NUM_CH-1:0] load;
  logic [WIDTH-1:0]  lane_data [NUM_CH];

`ifdef DEMUX_AUTOSEQ_EN
  ch_idx_t ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= ptr_q + ch_idx_t'(1);
    end
  end

  assign sel    = ptr_q;
  assign ch_ptr = ptr_q;
`else
  assign sel    = s;
  assign ch_ptr = '0;
`endif

  // A full lane can still take a byte when it is being drained this cycle.
  assign d_ready = !y_valid[sel] || y_ready[sel];
  assign accept  = d_valid && d_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load = ch_onehot(sel);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .din   (d),
      .dout  (lane_data[k]),
      .valid (y_valid[k]),
      .ready (y_ready[k])
    );
  end

  assign y0 = lane_data[0];
  assign y1 = lane_data[1];
  assign y2 = lane_data[2];
  assign y3 = lane_data[3];
  assign y4 = lane_data[4];
  assign y5 = lane_data[5];
  assign y6 = lane_data[6];
  assign y7 = lane_data[7];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (accept) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux8_buf.sv
// tb_demux8_buf
//   Self-checking bench for demux8_buf. Runs the DUT with CNT_W=4 so the
//   counter wrap is reachable quickly. A lane-level reference model
//   (per-lane byte + occupied flag, transfer count, pointer) tracks what
//   the outputs must be after every clock edge.
module tb_demux8_buf;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    d;
  logic [2:0]    s;
  logic          d_valid;
  logic          d_ready;
  logic [7:0]    y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0]    y_valid;
  logic [7:0]    y_ready;
  logic [2:0]    ch_ptr;
  logic [CW-1:0] xfer_cnt;
  logic [7:0]    y [8];

  int total = 0;
  int bad   = 0;

  bit [7:0] m_hold [8];
  bit       m_full [8];
  int       m_cnt;
  int       m_ptr;

  always #5 clk = ~clk;

  demux8_buf #(.WIDTH(8), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .s        (s),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .y4       (y4),
    .y5       (y5),
    .y6       (y6),
    .y7       (y7),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .ch_ptr   (ch_ptr),
    .xfer_cnt (xfer_cnt)
  );

  assign y[0] = y0;
  assign y[1] = y1;
  assign y[2] = y2;
  assign y[3] = y3;
  assign y[4] = y4;
  assign y[5] = y5;
  assign y[6] = y6;
  assign y[7] = y7;

  function automatic int m_sel();
`ifdef DEMUX_AUTOSEQ_EN
    return m_ptr;
`else
    return int'(s);
`endif
  endfunction

  function automatic bit m_ready();
    return !m_full[m_sel()] || y_ready[m_sel()];
  endfunction

  function automatic logic [7:0] m_valid();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_full[k];
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_tick();
    int sel;
    bit acc;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        m_hold[k] = 8'h00;
        m_full[k] = 1'b0;
      end
      m_cnt = 0;
      m_ptr = 0;
    end else begin
      sel = m_sel();
      acc = d_valid && m_ready();
      for (int k = 0; k < 8; k++) begin
        if (acc && k == sel) begin
          m_hold[k] = d;
          m_full[k] = 1'b1;
        end else if (m_full[k] && y_ready[k]) begin
          m_full[k] = 1'b0;
        end
      end
      if (acc) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
`ifdef DEMUX_AUTOSEQ_EN
        m_ptr = (m_ptr + 1) % 8;
`endif
      end
    end
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    d_valid = 1'b0;
    tick();
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    d_valid = 1'b1;
    d       = 8'h5A;
    s       = 3'd1;
    y_ready = 8'h00;
    tick();
    tick();
    total++;
    if (y_valid !== 8'h00) begin
      bad++;
      $display("FAIL reset_y_valid got=%h exp=00", y_valid);
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (y[k] !== 8'h00) begin
        bad++;
        $display("FAIL reset_y%0d got=%h exp=00", k, y[k]);
      end
    end
    total++;
    if (xfer_cnt !== '0 || ch_ptr !== 3'd0) begin
      bad++;
      $display("FAIL reset_cnt_ptr got=%0d/%0d exp=0/0", xfer_cnt, ch_ptr);
    end
    total++;
    if (d_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_d_ready got=%b exp=1", d_ready);
    end
    rst_n   = 1'b1;
    d_valid = 1'b0;
  endtask

`ifndef DEMUX_AUTOSEQ_EN
  task automatic test_routing();
    do_reset();
    y_ready = 8'h00;
    for (int k = 0; k < 8; k++) begin
      d       = 8'hA0 + 8'(k);
      s       = 3'(k);
      d_valid = 1'b1;
      tick();
    end
    d_valid = 1'b0;
    total++;
    if (y_valid !== 8'hFF) begin
      bad++;
      $display("FAIL route_y_valid got=%h exp=ff", y_valid);
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (y[k] !== 8'hA0 + 8'(k)) begin
        bad++;
        $display("FAIL route_y%0d got=%h exp=%h", k, y[k], 8'hA0 + 8'(k));
      end
    end
    total++;
    if (xfer_cnt !== CW'(8)) begin
      bad++;
      $display("FAIL route_cnt got=%0d exp=8", xfer_cnt);
    end
    d       = 8'h55;
    s       = 3'd3;
    d_valid = 1'b1;
    #1;
    total++;
    if (d_ready !== 1'b0) begin
      bad++;
      $display("FAIL route_ninth_ready got=%b exp=0", d_ready);
    end
    tick();
    d_valid = 1'b0;
    total++;
    if (y3 !== 8'hA3 || xfer_cnt !== CW'(8)) begin
      bad++;
      $display("FAIL route_ninth_blocked got=%h/%0d exp=a3/8", y3, xfer_cnt);
    end
  endtask

  task automatic test_stall_isolation();
    do_reset();
    y_ready = 8'h00;
    d = 8'h42; s = 3'd2; d_valid = 1'b1;
    tick();
    d = 8'h99; s = 3'd2;
    #1;
    total++;
    if (d_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_ready_s2 got=%b exp=0", d_ready);
    end
    d = 8'h77; s = 3'd5;
    #1;
    total++;
    if (d_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_ready_s5 got=%b exp=1", d_ready);
    end
    tick();
    d_valid = 1'b0;
    total++;
    if (y5 !== 8'h77 || y_valid[5] !== 1'b1) begin
      bad++;
      $display("FAIL stall_lane5 got=%h/%b exp=77/1", y5, y_valid[5]);
    end
    total++;
    if (y2 !== 8'h42 || y_valid[2] !== 1'b1) begin
      bad++;
      $display("FAIL stall_lane2 got=%h/%b exp=42/1", y2, y_valid[2]);
    end
  endtask

  task automatic test_drain_load();
    int n11 = 0;
    do_reset();
    y_ready = 8'h00;
    d = 8'h11; s = 3'd4; d_valid = 1'b1;
    tick();
    y_ready = 8'h10;
    d = 8'h22; s = 3'd4; d_valid = 1'b1;
    #1;
    total++;
    if (d_ready !== 1'b1) begin
      bad++;
      $display("FAIL dl_ready got=%b exp=1", d_ready);
    end
    if (y_valid[4] && y_ready[4] && y4 == 8'h11) n11++;
    tick();
    y_ready = 8'h00;
    d_valid = 1'b0;
    total++;
    if (y_valid[4] !== 1'b1 || y4 !== 8'h22) begin
      bad++;
      $display("FAIL dl_lane4 got=%b/%h exp=1/22", y_valid[4], y4);
    end
    if (y_valid[4] && y_ready[4] && y4 == 8'h11) n11++;
    tick();
    total++;
    if (n11 != 1 || y4 !== 8'h22) begin
      bad++;
      $display("FAIL dl_consumed_once got=%0d/%h exp=1/22", n11, y4);
    end
  endtask
`else
  task automatic test_autoseq();
    do_reset();
    y_ready = 8'hFF;
    s       = 3'b111;
    for (int i = 0; i < 10; i++) begin
      d       = 8'(i);
      d_valid = 1'b1;
      tick();
      total++;
      if (y[i % 8] !== 8'(i) || y_valid !== 8'(1 << (i % 8))) begin
        bad++;
        $display("FAIL autoseq_%0d got=%h/%h exp=%h/%h", i, y[i % 8], y_valid,
                 8'(i), 8'(1 << (i % 8)));
      end
    end
    d_valid = 1'b0;
    total++;
    if (ch_ptr !== 3'd2) begin
      bad++;
      $display("FAIL autoseq_ptr got=%0d exp=2", ch_ptr);
    end
  endtask
`endif

  task automatic test_counter_wrap();
    do_reset();
    y_ready = 8'hFF;
    for (int i = 0; i < 17; i++) begin
      d       = 8'($urandom);
      s       = 3'($urandom);
      d_valid = 1'b1;
      tick();
    end
    d_valid = 1'b0;
    total++;
    if (xfer_cnt !== CW'(1)) begin
      bad++;
      $display("FAIL wrap_cnt got=%0d exp=1", xfer_cnt);
    end
  endtask

  task automatic test_random();
    bit hold_in = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if (!hold_in) begin
        d_valid = ($urandom_range(0, 99) < 75);
        d       = 8'($urandom);
        s       = 3'($urandom);
      end
      y_ready = 8'($urandom);
      #1;
      total++;
      if (d_ready !== m_ready()) begin
        bad++;
        $display("FAIL rand_d_ready cyc=%0d got=%b exp=%b", c, d_ready, m_ready());
      end
      hold_in = rst_n && d_valid && !m_ready();
      tick();
      total++;
      if (y_valid !== m_valid()) begin
        bad++;
        $display("FAIL rand_y_valid cyc=%0d got=%h exp=%h", c, y_valid, m_valid());
      end
      for (int k = 0; k < 8; k++) begin
        total++;
        if (y[k] !== m_hold[k]) begin
          bad++;
          $display("FAIL rand_y%0d cyc=%0d got=%h exp=%h", k, c, y[k], m_hold[k]);
        end
      end
      total++;
      if (xfer_cnt !== CW'(m_cnt) || ch_ptr !== 3'(m_ptr)) begin
        bad++;
        $display("FAIL rand_cnt_ptr cyc=%0d got=%0d/%0d exp=%0d/%0d", c, xfer_cnt,
                 ch_ptr, m_cnt, m_ptr);
      end
    end
    rst_n   = 1'b1;
    d_valid = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    y_ready = 8'h00;
    for (int k = 0; k < 4; k++) begin
      d = 8'hC0 + 8'(k); s = 3'(k); d_valid = 1'b1;
      tick();
    end
    d_valid = 1'b0;
    rst_n   = 1'b0;
    tick();
    rst_n   = 1'b1;
    total++;
    if (y_valid !== 8'h00 || y0 !== 8'h00 || xfer_cnt !== '0) begin
      bad++;
      $display("FAIL midop_reset got=%h/%h/%0d exp=00/00/0", y_valid, y0, xfer_cnt);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    d       = 8'h00;
    s       = 3'd0;
    d_valid = 1'b0;
    y_ready = 8'h00;
    for (int k = 0; k < 8; k++) begin
      m_hold[k] = 8'h00;
      m_full[k] = 1'b0;
    end
    m_cnt = 0;
    m_ptr = 0;
    @(posedge clk);
    #1;
    test_reset();
`ifndef DEMUX_AUTOSEQ_EN
    test_routing();
    test_stall_isolation();
    test_drain_load();
`else
    test_autoseq();
`endif
    test_counter_wrap();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
